// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle: request in, staged resets / ready / request count out.
interface reset_sequencer_if #(
    parameter int unsigned STAGES = 3
);
    logic              reset_req;
    logic [STAGES-1:0] rst_stage_n;
    logic              ready;
    logic [7:0]        reset_count;

    // Upstream reset controller side
    modport master (
        output reset_req,
        input  rst_stage_n,
        input  ready,
        input  reset_count
    );

    // Sequencer side
    modport slave (
        input  reset_req,
        output rst_stage_n,
        output ready,
        output reset_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release sequencer: holds all stages in reset while requested,
// waits HOLD_CYCLES, then releases stage 0..STAGES-1 every STAGE_GAP cycles.
// Optional macro RESET_SEQUENCER_COUNT_EN enables the saturating reset_count.
module reset_sequencer #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned STAGE_GAP   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    reset_sequencer_if.slave    io_seq
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_IDLE    = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_hold;
    logic [CNT_W-1:0]  r_gap;
    logic [STAGES-1:0] r_stage_n;
    logic              r_ready;

    logic [1:0]        w_nxt_state;
    logic [CNT_W-1:0]  w_nxt_hold;
    logic [CNT_W-1:0]  w_nxt_gap;
    logic [STAGES-1:0] w_nxt_stage_n;
    logic              w_nxt_ready;
    logic [STAGES-1:0] w_shift_n;
    logic              w_req;

    assign w_req = io_seq.reset_req;

    // Next release pattern: shift a one in from bit 0 so release order is monotone
    generate
        if (STAGES == 1) begin : g_one
            assign w_shift_n = 1'b1;
        end else begin : g_multi
            assign w_shift_n = {r_stage_n[STAGES-2:0], 1'b1};
        end
    endgenerate

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HOLD;
            r_hold    <= '0;
            r_gap     <= '0;
            r_stage_n <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_hold    <= w_nxt_hold;
            r_gap     <= w_nxt_gap;
            r_stage_n <= w_nxt_stage_n;
            r_ready   <= w_nxt_ready;
        end
    end

    // Next-state and next-output logic; a request always wins and restarts from ASSERT
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_hold    = r_hold;
        w_nxt_gap     = r_gap;
        w_nxt_stage_n = r_stage_n;
        w_nxt_ready   = r_ready;
        if (w_req) begin
            w_nxt_state   = ST_ASSERT;
            w_nxt_hold    = '0;
            w_nxt_gap     = '0;
            w_nxt_stage_n = '0;
            w_nxt_ready   = 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_nxt_state = ST_HOLD;
                    w_nxt_hold  = '0;
                end
                ST_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        w_nxt_stage_n = w_shift_n;
                        w_nxt_gap     = '0;
                        if (&w_shift_n) begin
                            w_nxt_ready = 1'b1;
                            w_nxt_state = ST_IDLE;
                        end else begin
                            w_nxt_state = ST_RELEASE;
                        end
                    end else begin
                        w_nxt_hold = r_hold + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_gap == GAP_LAST) begin
                        w_nxt_stage_n = w_shift_n;
                        w_nxt_gap     = '0;
                        if (&w_shift_n) begin
                            w_nxt_ready = 1'b1;
                            w_nxt_state = ST_IDLE;
                        end
                    end else begin
                        w_nxt_gap = r_gap + CNT_W'(1);
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    assign io_seq.rst_stage_n = r_stage_n;
    assign io_seq.ready       = r_ready;

`ifdef RESET_SEQUENCER_COUNT_EN
    logic             r_req_d;
    logic [CNT_W-1:0] r_count;

    // Count rising edges of the request sample, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d <= 1'b0;
            r_count <= '0;
        end else begin
            r_req_d <= w_req;
            if (w_req && !r_req_d && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign io_seq.reset_count = r_count;
`else
    assign io_seq.reset_count = 8'h00;
`endif

endmodule
